// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter that shares one single-precision multiplier among N_REQ requesters.
// One operation in flight; tagged product returned on a single response port with timeout recovery.
module fp_mul_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned ID_W           = $clog2(N_REQ),
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [N_REQ-1:0]      req_valid_i,
    input  logic [32*N_REQ-1:0]   req_a_i,
    input  logic [32*N_REQ-1:0]   req_b_i,
    output logic [N_REQ-1:0]      req_ready_o,
    output logic                  mul_start_o,
    output logic [31:0]           mul_a_o,
    output logic [31:0]           mul_b_o,
    input  logic                  mul_done_i,
    input  logic [31:0]           mul_product_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [ID_W-1:0]       rsp_id_o,
    output logic [31:0]           rsp_product_o,
    output logic                  rsp_error_o,
    output logic                  busy_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned SUM_W  = ID_W + 1;
    localparam logic [DATA_W-1:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                start_q, start_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_product_q, rsp_product_d;
    logic                rsp_error_q, rsp_error_d;
    logic                busy_q, busy_d;

    logic                found_c;
    logic [ID_W-1:0]     grant_c;
    logic [DATA_W-1:0]   sel_a_c;
    logic [DATA_W-1:0]   sel_b_c;
    logic [DATA_W-1:0]   a_arr [N_REQ];
    logic [DATA_W-1:0]   b_arr [N_REQ];

    // Unpacked views of the packed operand buses.
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a_i[DATA_W*i +: DATA_W];
        assign b_arr[i] = req_b_i[DATA_W*i +: DATA_W];
    end

    // First valid requester at or after rr_ptr, wrapping at N_REQ.
    always_comb begin
        logic [SUM_W-1:0] sum;
        logic [ID_W-1:0]  idx;
        found_c = 1'b0;
        grant_c = '0;
        sel_a_c = '0;
        sel_b_c = '0;
        sum     = '0;
        idx     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + SUM_W'(k);
            if (sum >= SUM_W'(N_REQ)) begin
                sum = sum - SUM_W'(N_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!found_c && req_valid_i[idx]) begin
                found_c = 1'b1;
                grant_c = idx;
                sel_a_c = a_arr[idx];
                sel_b_c = b_arr[idx];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        cnt_d         = cnt_q;
        start_d       = 1'b0;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_product_d = rsp_product_q;
        rsp_error_d   = rsp_error_q;
        req_ready_o   = '0;

        case (state_q)
            S_IDLE: begin
                if (found_c) begin
                    req_ready_o[grant_c] = 1'b1;
                    grant_d = grant_c;
                    op_a_d  = sel_a_c;
                    op_b_d  = sel_b_c;
                    start_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A done coinciding with the timeout cycle takes priority.
                if (mul_done_i) begin
                    rsp_valid_d   = 1'b1;
                    rsp_id_d      = grant_q;
                    rsp_product_d = mul_product_i;
                    rsp_error_d   = 1'b0;
                    state_d       = S_RESP;
                end else if (cnt_q + CNT_W'(1) == CNT_W'(TIMEOUT_CYCLES)) begin
                    rsp_valid_d   = 1'b1;
                    rsp_id_d      = grant_q;
                    rsp_product_d = QNAN;
                    rsp_error_d   = 1'b1;
                    state_d       = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d   = 1'b0;
                    rsp_id_d      = '0;
                    rsp_product_d = '0;
                    rsp_error_d   = 1'b0;
                    op_a_d        = '0;
                    op_b_d        = '0;
                    rr_ptr_d      = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + ID_W'(1);
                    state_d       = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            cnt_q         <= '0;
            start_q       <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_product_q <= '0;
            rsp_error_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            cnt_q         <= cnt_d;
            start_q       <= start_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_product_q <= rsp_product_d;
            rsp_error_q   <= rsp_error_d;
            busy_q        <= busy_d;
        end
    end

    assign mul_start_o   = start_q;
    assign mul_a_o       = op_a_q;
    assign mul_b_o       = op_b_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_id_o      = rsp_id_q;
    assign rsp_product_o = rsp_product_q;
    assign rsp_error_o   = rsp_error_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: behavioural multiplier plus a transaction-level
// round-robin/latency reference model, directed scenarios then random traffic.
module tb_fp_mul_arbiter;

    localparam int N    = 4;
    localparam int TO   = 16;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic [N-1:0]    req_valid_i;
    logic [32*N-1:0] req_a_i;
    logic [32*N-1:0] req_b_i;
    logic [N-1:0]    req_ready_o;
    logic            mul_start_o;
    logic [31:0]     mul_a_o;
    logic [31:0]     mul_b_o;
    logic            mul_done_i;
    logic [31:0]     mul_product_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [1:0]      rsp_id_o;
    logic [31:0]     rsp_product_o;
    logic            rsp_error_o;
    logic            busy_o;

    fp_mul_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .req_valid_i   (req_valid_i),
        .req_a_i       (req_a_i),
        .req_b_i       (req_b_i),
        .req_ready_o   (req_ready_o),
        .mul_start_o   (mul_start_o),
        .mul_a_o       (mul_a_o),
        .mul_b_o       (mul_b_o),
        .mul_done_i    (mul_done_i),
        .mul_product_i (mul_product_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_id_o      (rsp_id_o),
        .rsp_product_o (rsp_product_o),
        .rsp_error_o   (rsp_error_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          rr_model = 0;
    int          mul_lat = 3;
    int          mul_rem = 0;
    logic [31:0] mul_pa, mul_pb;
    logic [31:0] tb_a [N];
    logic [31:0] tb_b [N];
    logic [31:0] last_prod;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic real f2r(input logic [31:0] x);
        real m;
        int  e;
        m = 1.0 + real'(x[22:0]) / 8388608.0;
        e = int'(x[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return x[31] ? -m : m;
    endfunction

    // Reference single-precision multiply for normal operands (mantissa truncated).
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] d;
        d = $realtobits(f2r(a) * f2r(b));
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    endfunction

    function automatic logic [31:0] rand_fp();
        return {1'($urandom), 8'($urandom_range(144, 110)), 23'($urandom)};
    endfunction

    function automatic int rr_pick(input int ptr, input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return 0;
    endfunction

    // Advance one cycle and run the multiplier model (fixed latency, 0 = never done).
    task automatic tick();
        @(posedge clk_i);
        #1;
        mul_done_i = 1'b0;
        if (mul_rem > 0) begin
            mul_rem--;
            if (mul_rem == 0) begin
                mul_done_i    = 1'b1;
                mul_product_i = fmul(mul_pa, mul_pb);
            end
        end
        if (mul_start_o) begin
            mul_pa  = mul_a_o;
            mul_pb  = mul_b_o;
            mul_rem = mul_lat;
        end
    endtask

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            req_a_i[32*i +: 32] = tb_a[i];
            req_b_i[32*i +: 32] = tb_b[i];
        end
    endtask

    // One full transaction: accept, issue, wait, response (optionally back-pressured).
    task automatic run_op(input logic [N-1:0] mask, input int lat, input int hold,
                          output int g, output int wait_cyc);
        logic [N-1:0] exp_oh;
        logic [31:0]  ea, eb, ep;
        logic         ee;
        int           cnt, bad, exp_lat;
        bit           ok_lat;
        req_valid_i = mask;
        drive_ops();
        mul_lat = lat;
        #1;
        wait_cyc = 0;
        g = rr_pick(rr_model, mask);
        exp_oh = '0;
        exp_oh[g] = 1'b1;
        while (req_ready_o == '0 && wait_cyc < 40) begin
            tick();
            wait_cyc++;
        end
        check("grant", 64'(req_ready_o), 64'(exp_oh));
        if (req_ready_o == '0) return;
        ea = tb_a[g];
        eb = tb_b[g];
        ok_lat = (lat > 0 && lat <= TO);
        ep = ok_lat ? fmul(ea, eb) : QNAN;
        ee = !ok_lat;
        exp_lat = ok_lat ? 2 + lat : 2 + TO;
        bad = 0;
        tick();
        cnt = 1;
        check("start", 64'(mul_start_o), 64'(1));
        check("mul_a", 64'(mul_a_o), 64'(ea));
        check("mul_b", 64'(mul_b_o), 64'(eb));
        while (!rsp_valid_o && cnt < 60) begin
            tick();
            cnt++;
            if (mul_start_o || req_ready_o != '0) bad++;
        end
        check("rsp_lat", 64'(cnt), 64'(exp_lat));
        check("rsp_id", 64'(rsp_id_o), 64'(g));
        check("rsp_prod", 64'(rsp_product_o), 64'(ep));
        check("rsp_err", 64'(rsp_error_o), 64'(ee));
        check("busy", 64'(busy_o), 64'(1));
        last_prod = rsp_product_o;
        for (int h = 0; h < hold; h++) begin
            tick();
            if (!rsp_valid_o || rsp_id_o != 2'(g) || rsp_product_o != ep || rsp_error_o != ee ||
                req_ready_o != '0 || mul_start_o) bad++;
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        if (rsp_valid_o || mul_a_o != '0 || mul_b_o != '0 || busy_o) bad++;
        check("quiet", 64'(bad), 64'(0));
        rr_model = (g + 1) % N;
    endtask

    initial begin
        int g, w, bad;
        reset_i       = 1'b1;
        req_valid_i   = '0;
        req_a_i       = '0;
        req_b_i       = '0;
        rsp_ready_i   = 1'b0;
        mul_done_i    = 1'b0;
        mul_product_i = '0;
        for (int i = 0; i < N; i++) begin
            tb_a[i] = rand_fp();
            tb_b[i] = rand_fp();
        end
        repeat (3) tick();
        reset_i = 1'b0;
        tick();
        check("rst_ready", 64'(req_ready_o), 64'(0));
        check("rst_start", 64'(mul_start_o), 64'(0));
        check("rst_a", 64'(mul_a_o), 64'(0));
        check("rst_b", 64'(mul_b_o), 64'(0));
        check("rst_valid", 64'(rsp_valid_o), 64'(0));
        check("rst_id", 64'(rsp_id_o), 64'(0));
        check("rst_prod", 64'(rsp_product_o), 64'(0));
        check("rst_err", 64'(rsp_error_o), 64'(0));
        check("rst_busy", 64'(busy_o), 64'(0));

        // Single multiply and sign handling
        tb_a[2] = 32'h4000_0000; tb_b[2] = 32'h4040_0000;
        run_op(4'b0100, 3, 0, g, w);
        check("t1_prod", 64'(last_prod), 64'(32'h40C0_0000));
        tb_a[0] = 32'hBFC0_0000; tb_b[0] = 32'h4000_0000;
        run_op(4'b0001, 3, 0, g, w);
        check("t2_prod", 64'(last_prod), 64'(32'hC040_0000));

        // Round-robin fairness and wrap-around
        run_op(4'b1000, 3, 0, g, w);
        for (int i = 0; i < 5; i++) begin
            run_op(4'b1111, 3, 0, g, w);
            check("rr_order", 64'(g), 64'(i % N));
        end
        run_op(4'b0100, 2, 0, g, w);
        run_op(4'b0010, 2, 0, g, w);
        check("rr_wrap", 64'(g), 64'(1));

        // Back-pressure and next-grant timing
        run_op(4'b1111, 3, 5, g, w);
        run_op(4'b1111, 3, 0, g, w);
        check("bp_next", 64'(w), 64'(0));

        // Timeout, done-wins-tie, late done, recovery
        run_op(4'b0001, 0, 0, g, w);
        run_op(4'b0001, 3, 0, g, w);
        run_op(4'b0010, TO, 2, g, w);
        run_op(4'b0100, TO + 1, 2, g, w);

        // Reset in second WAIT cycle
        req_valid_i = 4'b0100;
        mul_lat = 10;
        #1;
        check("rst_op_grant", 64'(req_ready_o), 64'(4'b0001 << rr_pick(rr_model, 4'b0100)));
        tick();
        req_valid_i = '0;
        tick();
        tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        mul_rem = 0;
        check("mid_start", 64'(mul_start_o), 64'(0));
        check("mid_a", 64'(mul_a_o), 64'(0));
        check("mid_valid", 64'(rsp_valid_o), 64'(0));
        check("mid_busy", 64'(busy_o), 64'(0));
        mul_done_i    = 1'b1;
        mul_product_i = 32'h1234_5678;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid_o || busy_o || rsp_product_o != '0 || mul_start_o) bad++;
        end
        check("late_done", 64'(bad), 64'(0));
        rr_model = 0;
        run_op(4'b1001, 3, 0, g, w);

        // Random traffic
        for (int it = 0; it < 40; it++) begin
            int r, lat;
            for (int i = 0; i < N; i++) begin
                tb_a[i] = rand_fp();
                tb_b[i] = rand_fp();
            end
            r = $urandom_range(9, 0);
            lat = (r == 0) ? 0 : (r == 1) ? TO : (r == 2) ? TO + 1 : $urandom_range(6, 1);
            run_op(4'($urandom_range(15, 1)), lat, $urandom_range(3, 0), g, w);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
